// File: rtl/rom_scan_pkg.sv
// Shared types and default sizing for the ROM address scan sequencer.
package rom_scan_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 2;
    localparam int DEPTH_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } beat_t;

endpackage

// File: rtl/rom_scan_sequencer_if.sv
// Valid/ready stream carrying one (address, data) ROM beat per transfer.
interface rom_scan_sequencer_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 2
) ();

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/rom_scan_out_reg.sv
// Single-entry valid/ready output register for ROM scan beats.
module rom_scan_out_reg
    import rom_scan_pkg::*;
#(
    parameter type BEAT_T = beat_t
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  BEAT_T                 beat_i,
    output logic                  slot_free_o,
    output logic                  fire_o,
    rom_scan_sequencer_if.master  out_if
);

    BEAT_T beat_q;
    logic  valid_q;

    // A slot drained this cycle can be refilled in the same cycle.
    assign fire_o      = valid_q && out_if.out_ready;
    assign slot_free_o = !valid_q || out_if.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            beat_q  <= beat_i;
        end else if (fire_o) begin
            valid_q <= 1'b0;
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_addr  = beat_q.addr;
    assign out_if.out_data  = beat_q.data;

endmodule

// File: rtl/rom_scan_sequencer.sv
// Sweeps ROM addresses 0..DEPTH-1 on start and streams (addr, data) beats.
// Optional running checksum of emitted data under `ROM_SCAN_CHECKSUM_EN.
module rom_scan_sequencer
    import rom_scan_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    output logic [ADDR_W-1:0]        rom_addr_o,
    input  logic [DATA_W-1:0]        rom_data_i,
    rom_scan_sequencer_if.master     out_if,
    output logic                     busy_o,
    output logic                     done_o
`ifdef ROM_SCAN_CHECKSUM_EN
    ,
    output logic [DATA_W+ADDR_W-1:0] checksum_o
`endif
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } seq_beat_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              busy_q;
    logic              done_q;
    logic              slot_free;
    logic              fire;
    logic              capture;
    logic              start_acc;
    seq_beat_t         beat_d;

    assign start_acc  = (state_q == IDLE) && start_i;
    assign capture    = (state_q == SCAN) && slot_free;
    assign cnt_d      = cnt_q + ADDR_W'(1);
    assign beat_d     = '{addr: cnt_q, data: rom_data_i};
    assign rom_addr_o = (state_q == SCAN) ? cnt_q : '0;

    rom_scan_out_reg #(
        .BEAT_T (seq_beat_t)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (capture),
        .beat_i      (beat_d),
        .slot_free_o (slot_free),
        .fire_o      (fire),
        .out_if      (out_if)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= SCAN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    // Counter stops at the last address so it never wraps.
                    if (capture) begin
                        if (cnt_q == LAST) state_q <= DRAIN;
                        else               cnt_q   <= cnt_d;
                    end
                end
                DRAIN: begin
                    if (fire) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

`ifdef ROM_SCAN_CHECKSUM_EN
    localparam int CS_W = DATA_W + ADDR_W;

    logic [CS_W-1:0] csum_q;
    logic [CS_W-1:0] csum_d;

    assign csum_d = csum_q + CS_W'(out_if.out_data);

    // Accumulates every accepted beat; holds after done until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         csum_q <= '0;
        else if (start_acc) csum_q <= '0;
        else if (fire)      csum_q <= csum_d;
    end

    assign checksum_o = csum_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule
